// File: rtl/jk_reg_bank.sv
// Purpose: WIDTH-bit JK flip-flop bank with JK, count-up, count-down and shift-left modes (macro JK_REG_BANK_SATURATE_EN makes counters saturate).
// Latency: q, qbar and chg update one clk edge after inputs are sampled; tc is combinational from q and mode.
// Backpressure: none; en=0 holds q/qbar and zeroes chg, sclr overrides en and mode.
module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic [WIDTH-1:0] chg
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] next_q;
    logic             q_all_ones;
    logic             q_all_zero;

    assign q_all_ones = &q;
    assign q_all_zero = ~|q;
    assign shift_val  = {q[WIDTH-2:0], j[0]};

    // Translate the selected mode into a J/K drive per bit; counters toggle a bit when all lower bits are at the carry/borrow value.
    always_comb begin : jk_drive
        logic carry;
        carry = 1'b1;
        j_drv = '0;
        k_drv = '0;
        case (mode)
            MODE_JK: begin
                j_drv = j;
                k_drv = k;
            end
            MODE_UP: begin
                for (int i = 0; i < WIDTH; i++) begin
                    j_drv[i] = carry;
                    k_drv[i] = carry;
                    carry    = carry & q[i];
                end
            end
            MODE_DOWN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    j_drv[i] = carry;
                    k_drv[i] = carry;
                    carry    = carry & ~q[i];
                end
            end
            MODE_SHIFT: begin
                // J = target, K = ~target forces each bit to the shifted value.
                j_drv = shift_val;
                k_drv = ~shift_val;
            end
            default: begin
                j_drv = '0;
                k_drv = '0;
            end
        endcase
`ifdef JK_REG_BANK_SATURATE_EN
        // At the terminal value the counter holds instead of wrapping.
        if ((mode == MODE_UP && q_all_ones) || (mode == MODE_DOWN && q_all_zero)) begin
            j_drv = '0;
            k_drv = '0;
        end
`endif
    end

    // Characteristic JK equation applied bitwise: set on J, clear on K, toggle on both.
    assign next_q = (j_drv & ~q) | (~k_drv & q);

    // Terminal count is only meaningful in the two counting modes.
    assign tc = ((mode == MODE_UP) && q_all_ones) || ((mode == MODE_DOWN) && q_all_zero);

    // State, complement and change mask registers; qbar is its own flop kept as ~q.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q    <= RESET_VAL;
            qbar <= ~RESET_VAL;
            chg  <= '0;
        end else if (sclr) begin
            q    <= RESET_VAL;
            qbar <= ~RESET_VAL;
            chg  <= q ^ RESET_VAL;
        end else if (en) begin
            q    <= next_q;
            qbar <= ~next_q;
            chg  <= q ^ next_q;
        end else begin
            chg  <= '0;
        end
    end

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       en = 1'b0;
    logic       sclr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] j = 8'h00;
    logic [7:0] k = 8'h00;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       tc;
    logic [7:0] chg;

    int tests = 0;
    int fails = 0;

    // Reference state
    logic [7:0] mq;
    logic [7:0] mchg;

    jk_reg_bank #(.WIDTH(8), .RESET_VAL(RV)) dut (
        .clk(clk), .clr_n(clr_n), .en(en), .sclr(sclr), .mode(mode),
        .j(j), .k(k), .q(q), .qbar(qbar), .tc(tc), .chg(chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_tc(input logic [1:0] m, input logic [7:0] cur);
        return (m == 2'd1 && cur == 8'hFF) || (m == 2'd2 && cur == 8'h00);
    endfunction

    // Next-state rules written arithmetically from the mode definitions.
    function automatic logic [7:0] model_next(input logic e, input logic s, input logic [1:0] m,
                                              input logic [7:0] jj, input logic [7:0] kk,
                                              input logic [7:0] cur);
        logic [7:0] n;
        if (s) return RV;
        if (!e) return cur;
        case (m)
            2'd0: n = (jj & ~kk) | (~jj & ~kk & cur) | (jj & kk & ~cur);
            2'd1: begin
`ifdef JK_REG_BANK_SATURATE_EN
                n = (cur == 8'hFF) ? cur : 8'(cur + 1);
`else
                n = 8'(cur + 1);
`endif
            end
            2'd2: begin
`ifdef JK_REG_BANK_SATURATE_EN
                n = (cur == 8'h00) ? cur : 8'(cur - 1);
`else
                n = 8'(cur - 1);
`endif
            end
            default: n = {cur[6:0], jj[0]};
        endcase
        return n;
    endfunction

    // One clocked step: drive at negedge, check tc, then check registers after the edge.
    task automatic apply(input string tag, input logic e, input logic s, input logic [1:0] m,
                         input logic [7:0] jj, input logic [7:0] kk);
        logic [7:0] n;
        @(negedge clk);
        en = e; sclr = s; mode = m; j = jj; k = kk;
        #1;
        chk({tag, ".tc"}, {7'd0, tc}, {7'd0, model_tc(m, mq)});
        n = model_next(e, s, m, jj, kk, mq);
        mchg = (s || e) ? (mq ^ n) : 8'h00;
        mq = n;
        @(posedge clk);
        #1;
        chk({tag, ".q"}, q, mq);
        chk({tag, ".qbar"}, qbar, ~mq);
        chk({tag, ".chg"}, chg, mchg);
    endtask

    initial begin
        // Asynchronous reset with no clock edge involved
        #1 clr_n = 1'b0;
        #1;
        chk("rst.q", q, 8'hA5);
        chk("rst.qbar", qbar, 8'h5A);
        chk("rst.chg", chg, 8'h00);
        mq = RV; mchg = 8'h00;
        @(negedge clk);
        clr_n = 1'b1;

        // JK mode
        apply("jk_load", 1, 0, 2'd0, 8'h0F, 8'hF0);
        chk("jk_load.const", q, 8'h0F);
        apply("jk_mix", 1, 0, 2'd0, 8'hF0, 8'h0C);
        chk("jk_mix.const_q", q, 8'hF3);
        chk("jk_mix.const_chg", chg, 8'hFC);
        apply("jk_tog", 1, 0, 2'd0, 8'hFF, 8'hFF);
        chk("jk_tog.const_q", q, 8'h0C);
        chk("jk_tog.const_qbar", qbar, 8'hF3);

        // Count up across the wrap point
        apply("up_load", 1, 0, 2'd0, 8'hFE, 8'h01);
        for (int i = 0; i < 3; i++) apply("up", 1, 0, 2'd1, $urandom, $urandom);
`ifdef JK_REG_BANK_SATURATE_EN
        chk("up.const", q, 8'hFF);
`else
        chk("up.const", q, 8'h01);
`endif

        // Count down across zero
        apply("dn_load", 1, 0, 2'd0, 8'h01, 8'hFE);
        for (int i = 0; i < 2; i++) apply("dn", 1, 0, 2'd2, $urandom, $urandom);
`ifdef JK_REG_BANK_SATURATE_EN
        chk("dn.const", q, 8'h00);
`else
        chk("dn.const", q, 8'hFF);
`endif

        // Shift with k toggling
        apply("sh_load", 1, 0, 2'd0, 8'h81, 8'h7E);
        apply("sh1", 1, 0, 2'd3, 8'h01, 8'hFF);
        apply("sh2", 1, 0, 2'd3, 8'h00, 8'h00);
        apply("sh3", 1, 0, 2'd3, 8'h01, 8'hAA);
        chk("sh.const", q, 8'h0D);

        // Priority: sclr beats en=0, then hold with en=0
        apply("sclr", 0, 1, 2'd1, 8'h00, 8'h00);
        chk("sclr.const", q, RV);
        apply("pre_hold", 1, 0, 2'd0, 8'h3C, 8'hC3);
        for (int i = 0; i < 4; i++) apply("hold", 0, 0, $urandom, $urandom, $urandom);

        // Asynchronous reset mid-count between edges, overriding sclr and counting
        apply("cnt", 1, 0, 2'd1, 8'h00, 8'h00);
        #2 clr_n = 1'b0;
        #1;
        chk("arst.q", q, RV);
        chk("arst.qbar", qbar, ~RV);
        chk("arst.chg", chg, 8'h00);
        @(negedge clk);
        en = 1'b1; sclr = 1'b1; mode = 2'd1;
        @(posedge clk);
        #1;
        chk("arst_hold.q", q, RV);
        chk("arst_hold.chg", chg, 8'h00);
        mq = RV; mchg = 8'h00;
        @(negedge clk);
        clr_n = 1'b1;

        // Randomised mix of all modes, enables and clears
        for (int i = 0; i < 300; i++) begin
            apply("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
